// File: rtl/iobus_timer_periph.sv
// iobus_timer_periph
//   Memory-mapped responder on the MCU IO bus. It holds an LED register,
//   a synchronized copy of the board switches and a prescaled 32-bit
//   countdown timer. The timer has a sticky expiry flag and a level
//   interrupt toward the MCU.
//
//   Register window: 256 bytes at BASE_ADDR. The word offset is IOBUS_ADDR[7:2].
//     0x00 LEDS     RW [15:0]
//     0x04 SW       RO synchronized SWITCHES
//     0x08 CTRL     RW [2:0] = {IRQ_EN, AUTO_RELOAD, EN}
//     0x0C LOAD     RW [31:0]
//     0x10 COUNT    RO; any write restarts COUNT from LOAD
//     0x14 STATUS   bit0 EXPIRED, write-1-to-clear
//     0x18 PRESCALE RW [PRESCALE_W-1:0]
//
// Ports:
//   CLK, RST          clock and asynchronous active-high reset
//   IOBUS_ADDR/OUT/WR MCU address, write data and write strobe
//   IOBUS_IN          combinational read data (0 on a miss or unmapped offset)
//   SWITCHES          asynchronous switch inputs
//   LEDS              LED register
//   INTR              registered interrupt = EXPIRED & IRQ_EN, one cycle late
module iobus_timer_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
    parameter int          SYNC_STAGES = 2,   // must be >= 2
    parameter int          PRESCALE_W  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    input  logic [15:0] SWITCHES,
    output logic [15:0] LEDS,
    output logic        INTR
);

    localparam logic [5:0] REG_LEDS   = 6'h00;
    localparam logic [5:0] REG_SW     = 6'h01;
    localparam logic [5:0] REG_CTRL   = 6'h02;
    localparam logic [5:0] REG_LOAD   = 6'h03;
    localparam logic [5:0] REG_COUNT  = 6'h04;
    localparam logic [5:0] REG_STATUS = 6'h05;
    localparam logic [5:0] REG_PRESC  = 6'h06;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // ---------------- address decode ----------------
    logic       hit;
    logic [5:0] sel;
    logic       wr_en;
    logic       unused_addr_lo;

    assign hit            = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
    assign sel            = IOBUS_ADDR[7:2];
    assign wr_en          = IOBUS_WR & hit;
    assign unused_addr_lo = ^IOBUS_ADDR[1:0];  // byte lanes are ignored

    logic wr_leds, wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    assign wr_leds   = wr_en && (sel == REG_LEDS);
    assign wr_ctrl   = wr_en && (sel == REG_CTRL);
    assign wr_load   = wr_en && (sel == REG_LOAD);
    assign wr_count  = wr_en && (sel == REG_COUNT);
    assign wr_status = wr_en && (sel == REG_STATUS);
    assign wr_presc  = wr_en && (sel == REG_PRESC);

    // ---------------- state ----------------
    state_t                  state_q,   state_d;
    logic [15:0]             leds_q,    leds_d;
    logic [2:0]              ctrl_q,    ctrl_d;
    logic [31:0]             load_q,    load_d;
    logic [31:0]             count_q,   count_d;
    logic [PRESCALE_W-1:0]   presc_q,   presc_d;
    logic [PRESCALE_W-1:0]   pcnt_q,    pcnt_d;
    logic                    expired_q, expired_d;
    logic                    intr_q,    intr_d;
    logic                    tick;
    logic                    expiry;

    // ---------------- switch synchronizer ----------------
    logic [SYNC_STAGES-1:0][15:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= SWITCHES;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ---------------- register update ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            leds_q    <= '0;
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            expired_q <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            leds_q    <= leds_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            expired_q <= expired_d;
            intr_q    <= intr_d;
        end
    end

    // ---------------- next state / timer FSM ----------------
    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        presc_d   = presc_q;
        pcnt_d    = '0;           // the prescaler sits at 0 outside RUN
        expired_d = expired_q;
        tick      = 1'b0;
        expiry    = 1'b0;

        if (wr_leds)  leds_d  = IOBUS_OUT[15:0];
        if (wr_load)  load_d  = IOBUS_OUT;
        if (wr_presc) presc_d = IOBUS_OUT[PRESCALE_W-1:0];

        // Timer step. The tick period is PRESCALE+1 cycles. The count reaches
        // 0 and is then held for one more tick before the timer expires.
        // Together this gives (LOAD+1)*(PRESCALE+1) cycles from reload to expiry.
        if (state_q == S_RUN) begin
            tick   = (pcnt_q == presc_q);
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    expiry = 1'b1;
                    if (ctrl_q[1]) begin
                        count_d = load_q;
                    end else begin
                        state_d = S_DONE;
                        count_d = '0;
                    end
                end
            end
        end

        // A write to COUNT restarts the countdown and wins over a tick on the same edge.
        if (wr_count) begin
            count_d = load_q;
            pcnt_d  = '0;
        end

        // A CTRL write overrides the timer step. An expiry on the same edge
        // still sets EXPIRED below.
        if (wr_ctrl) begin
            ctrl_d = IOBUS_OUT[2:0];
            pcnt_d = '0;
            if (IOBUS_OUT[0]) begin
                state_d = S_RUN;
                count_d = load_q;
            end else begin
                state_d = S_IDLE;
                count_d = count_q;
            end
        end

        // W1C is applied first so that a set on the same edge wins.
        if (wr_status && IOBUS_OUT[0]) expired_d = 1'b0;
        if (expiry)                    expired_d = 1'b1;
    end

    assign intr_d = expired_q & ctrl_q[2];

    // ---------------- read mux ----------------
    always_comb begin
        IOBUS_IN = '0;
        if (hit) begin
            case (sel)
                REG_LEDS:   IOBUS_IN[15:0] = leds_q;
                REG_SW:     IOBUS_IN[15:0] = sync_q[SYNC_STAGES-1];
                REG_CTRL:   IOBUS_IN[2:0]  = ctrl_q;
                REG_LOAD:   IOBUS_IN       = load_q;
                REG_COUNT:  IOBUS_IN       = count_q;
                REG_STATUS: IOBUS_IN[0]    = expired_q;
                REG_PRESC:  IOBUS_IN[PRESCALE_W-1:0] = presc_q;
                default:    IOBUS_IN       = '0;
            endcase
        end
    end

    assign LEDS = leds_q;
    assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_timer_periph.sv
// Directed testbench for iobus_timer_periph. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_iobus_timer_periph;

    localparam logic [31:0] A_LEDS   = 32'h1100_0000;
    localparam logic [31:0] A_SW     = 32'h1100_0004;
    localparam logic [31:0] A_CTRL   = 32'h1100_0008;
    localparam logic [31:0] A_LOAD   = 32'h1100_000C;
    localparam logic [31:0] A_COUNT  = 32'h1100_0010;
    localparam logic [31:0] A_STATUS = 32'h1100_0014;
    localparam logic [31:0] A_PRESC  = 32'h1100_0018;
    localparam logic [31:0] A_UNMAP  = 32'h1100_0020;

    logic        CLK, RST;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
    logic        IOBUS_WR;
    logic [15:0] SWITCHES, LEDS;
    logic        INTR;

    int checks = 0;
    int errors = 0;

    iobus_timer_periph dut (
        .CLK        (CLK),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .SWITCHES   (SWITCHES),
        .LEDS       (LEDS),
        .INTR       (INTR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge. The write lands on the next rising edge.
    // The task returns on the falling edge after that.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        IOBUS_ADDR = a;
        #1;
        chk(tag, IOBUS_IN, exp);
    endtask

    initial begin
        logic [31:0] ar_exp [6];
        ar_exp = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};

        RST = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0; SWITCHES = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // reset state
        chk("rst_intr", {31'b0, INTR}, 32'd0);
        chk("rst_leds", {16'b0, LEDS}, 32'd0);
        rd_chk("rst_ctrl",   A_CTRL,   32'd0);
        rd_chk("rst_load",   A_LOAD,   32'd0);
        rd_chk("rst_count",  A_COUNT,  32'd0);
        rd_chk("rst_status", A_STATUS, 32'd0);

        // LED path, address miss and unmapped offset
        bus_wr(A_LEDS, 32'h0000_A5A5);
        chk("led_wr", {16'b0, LEDS}, 32'h0000_A5A5);
        rd_chk("led_rd", A_LEDS, 32'h0000_A5A5);
        bus_wr(32'h1200_0000, 32'h0000_1234);
        chk("led_miss", {16'b0, LEDS}, 32'h0000_A5A5);
        rd_chk("miss_rd", 32'h1200_0000, 32'd0);
        rd_chk("unmap_rd", A_UNMAP, 32'd0);
        bus_wr(A_UNMAP, 32'hFFFF_FFFF);
        chk("unmap_wr", {16'b0, LEDS}, 32'h0000_A5A5);

        // switch synchronizer: 2 edges of latency
        SWITCHES = 16'h00F0;
        @(negedge CLK);
        rd_chk("sw_1edge", A_SW, 32'd0);
        @(negedge CLK);
        rd_chk("sw_2edge", A_SW, 32'h0000_00F0);

        // one-shot timer: PRESCALE=1, LOAD=3 -> expiry 8 cycles after the CTRL write
        bus_wr(A_PRESC, 32'd1);
        bus_wr(A_LOAD, 32'd3);
        bus_wr(A_CTRL, 32'd5);
        rd_chk("os_ctrl", A_CTRL, 32'd5);
        rd_chk("os_cnt0", A_COUNT, 32'd3);
        repeat (7) @(negedge CLK);
        rd_chk("os_st7", A_STATUS, 32'd0);
        rd_chk("os_cnt7", A_COUNT, 32'd0);
        @(negedge CLK);
        rd_chk("os_st8", A_STATUS, 32'd1);
        chk("os_intr8", {31'b0, INTR}, 32'd0);
        @(negedge CLK);
        chk("os_intr9", {31'b0, INTR}, 32'd1);
        repeat (10) @(negedge CLK);
        rd_chk("os_done_cnt", A_COUNT, 32'd0);
        bus_wr(A_STATUS, 32'd0);
        rd_chk("os_w0", A_STATUS, 32'd1);
        bus_wr(A_STATUS, 32'd1);
        rd_chk("os_w1c", A_STATUS, 32'd0);
        chk("os_intr_lag", {31'b0, INTR}, 32'd1);
        @(negedge CLK);
        chk("os_intr_fall", {31'b0, INTR}, 32'd0);
        repeat (10) @(negedge CLK);
        rd_chk("os_no_reexp", A_STATUS, 32'd0);

        // auto-reload: PRESCALE=0, LOAD=2 -> 2,1,0,2,1,0
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_PRESC, 32'd0);
        bus_wr(A_LOAD, 32'd2);
        bus_wr(A_CTRL, 32'd3);
        for (int i = 0; i < 6; i++) begin
            rd_chk($sformatf("ar_cnt%0d", i), A_COUNT, ar_exp[i]);
            if (i == 2) rd_chk("ar_st_pre", A_STATUS, 32'd0);
            if (i == 3) rd_chk("ar_st_wrap", A_STATUS, 32'd1);
            chk($sformatf("ar_intr%0d", i), {31'b0, INTR}, 32'd0);
            @(negedge CLK);
        end

        // W1C on the expiry edge: set wins
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_STATUS, 32'd1);
        rd_chk("race_clr", A_STATUS, 32'd0);
        bus_wr(A_CTRL, 32'd3);          // reload edge E0; expiry at E3
        repeat (2) @(negedge CLK);
        bus_wr(A_STATUS, 32'd1);        // lands on E3
        rd_chk("race_set_wins", A_STATUS, 32'd1);
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_STATUS, 32'd1);
        rd_chk("race_late_clr", A_STATUS, 32'd0);

        // restart and disable: PRESCALE=3, LOAD=10 -> ticks at E4, E8, ...
        bus_wr(A_LOAD, 32'd10);
        bus_wr(A_PRESC, 32'd3);
        bus_wr(A_CTRL, 32'd1);
        rd_chk("rs_cnt0", A_COUNT, 32'd10);
        repeat (7) @(negedge CLK);
        rd_chk("rs_cnt7", A_COUNT, 32'd9);
        bus_wr(A_COUNT, 32'd0);         // same edge as a tick: restart wins
        rd_chk("rs_restart", A_COUNT, 32'd10);
        repeat (3) @(negedge CLK);
        rd_chk("rs_pre_tick", A_COUNT, 32'd10);
        @(negedge CLK);
        rd_chk("rs_tick", A_COUNT, 32'd9);
        bus_wr(A_CTRL, 32'd0);
        repeat (20) @(negedge CLK);
        rd_chk("rs_frozen", A_COUNT, 32'd9);
        rd_chk("rs_no_exp", A_STATUS, 32'd0);

        // asynchronous reset mid-run with INTR high
        bus_wr(A_LEDS, 32'h0000_5A5A);
        bus_wr(A_LOAD, 32'd0);
        bus_wr(A_PRESC, 32'd0);
        bus_wr(A_CTRL, 32'd7);
        repeat (3) @(negedge CLK);
        chk("mr_intr_hi", {31'b0, INTR}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mr_intr_async", {31'b0, INTR}, 32'd0);
        chk("mr_leds", {16'b0, LEDS}, 32'd0);
        rd_chk("mr_leds_rd", A_LEDS,   32'd0);
        rd_chk("mr_ctrl",    A_CTRL,   32'd0);
        rd_chk("mr_load",    A_LOAD,   32'd0);
        rd_chk("mr_count",   A_COUNT,  32'd0);
        rd_chk("mr_status",  A_STATUS, 32'd0);
        rd_chk("mr_unmap",   A_UNMAP,  32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        rd_chk("mr_presc", A_PRESC, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
